// File: rtl/instr_fetch_port_pkg.sv
// instr_fetch_port_pkg: shared constants for the instruction-fetch port.
//   Exception codes returned to the fetch stage, line geometry, the FSM
//   state type and a helper that turns a line tag into its base address.
package instr_fetch_port_pkg;

    localparam int EXC_CODE_WIDTH = 5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'd0;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = 5'd4;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_IBE  = 5'd6;

    localparam int LINE_WORDS = 4;                // only 4 is supported
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int TAG_W      = 32 - IDX_W - 2;   // addr[31:4]

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,    // demand refill of the line that missed
        ST_PREF     // speculative fill of the next line
    } ifp_state_t;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t);
        return {t, {(IDX_W + 2){1'b0}}};
    endfunction

endpackage

// File: rtl/instr_fetch_port_line_buf.sv
// ifp_line_buf: one instruction line (tag, valid, LINE_WORDS words).
//   clk, rst       : clock, async active-high reset
//   clr            : drop valid (flush)
//   load, load_tag : start a new fill: latch tag, drop valid
//   we, widx, wdata: single word write port
//   set_valid      : mark line valid (same edge as the last word write)
//   lookup_tag/idx : combinational compare/read
//   hit, rdata     : valid && tag match; word at lookup_idx
module ifp_line_buf
    import instr_fetch_port_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [31:0]       wdata,
    input  logic              set_valid,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic [IDX_W-1:0]  lookup_idx,
    output logic              hit,
    output logic [31:0]       rdata
);

    logic                          valid;
    logic [TAG_W-1:0]              tag;
    logic [LINE_WORDS-1:0][31:0]   words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            words <= '0;
        end else begin
            if (clr || load)    valid <= 1'b0;
            else if (set_valid) valid <= 1'b1;
            if (load) tag <= load_tag;
            if (we)   words[widx] <= wdata;
        end
    end

    assign hit   = valid && (tag == lookup_tag);
    assign rdata = words[lookup_idx];

endmodule

// File: rtl/instr_fetch_port.sv
// instr_fetch_port: memory-side responder for instruction fetch.
//   Serves hits, misaligned and bus-error fetches in the same cycle and
//   stalls the fetch stage while a 4-word line is refilled over the bus.
//   clk, rst                    : clock, async active-high reset
//   fetch_addr                  : byte address (held while fetch_stall)
//   fetch_data, fetch_exc_code  : combinational response
//   fetch_stall                 : fetch not served this cycle
//   flush                       : invalidate all buffered lines
//   bus_req, bus_addr           : read request, held until bus_ack
//   bus_ack, bus_rdata, bus_err : read completion
// Build option: IFP_PREFETCH_EN adds a second line that is speculatively
//   filled with the next sequential line after each demand fill.
module instr_fetch_port
    import instr_fetch_port_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               fetch_addr,
    output logic [31:0]               fetch_data,
    output logic [EXC_CODE_WIDTH-1:0] fetch_exc_code,
    output logic                      fetch_stall,
    input  logic                      flush,
    output logic                      bus_req,
    output logic [31:0]               bus_addr,
    input  logic                      bus_ack,
    input  logic [31:0]               bus_rdata,
    input  logic                      bus_err
);

`ifdef IFP_PREFETCH_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    ifp_state_t              state;
    logic [TAG_W-1:0]        fill_tag, err_tag, ld_tag;
    logic [IDX_W-1:0]        word_cnt;
    logic                    err_valid, flush_pending;
    logic                    dsel;      // buffer owning demand fills
    logic                    fill_sel;  // buffer written by the current fill

    logic [NBUF-1:0]         buf_hit, buf_load, buf_we, buf_set;
    logic [NBUF-1:0][31:0]   buf_rdata;
    logic [31:0]             hit_data;

    logic [TAG_W-1:0]        tag;
    logic [IDX_W-1:0]        idx;
    logic                    aligned, hit_any, err_hit, miss, ack_ok, last_word;

    assign tag       = fetch_addr[31:IDX_W+2];
    assign idx       = fetch_addr[IDX_W+1:2];
    assign aligned   = (fetch_addr[1:0] == 2'b00);
    assign hit_any   = |buf_hit;
    assign err_hit   = err_valid && (err_tag == tag);
    assign miss      = aligned && !hit_any && !err_hit;
    // bus_req is high in every non-idle state, so gating on state also
    // discards stray acks while no request is outstanding
    assign ack_ok    = (state != ST_IDLE) && bus_ack && !bus_err;
    assign last_word = (word_cnt == IDX_W'(LINE_WORDS - 1));

`ifdef IFP_PREFETCH_EN
    logic pf_pending;
    assign fill_sel = (state == ST_PREF) ? ~dsel : dsel;
`else
    assign dsel     = 1'b0;
    assign fill_sel = dsel;
`endif

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < NBUF; i++)
            if (buf_hit[i]) hit_data = buf_rdata[i];
    end

    assign fetch_data     = (aligned && hit_any) ? hit_data : '0;
    assign fetch_exc_code = !aligned             ? EC_ADEL :
                            (!hit_any && err_hit) ? EC_IBE  : EC_NONE;
    assign fetch_stall    = miss;

    // Buffer control. A demand fill reuses the demand buffer in place, so
    // the line it held is lost even if the fill later fails.
    always_comb begin
        buf_load = '0;
        buf_we   = '0;
        buf_set  = '0;
        ld_tag   = tag;
        case (state)
            ST_IDLE: begin
                if (!flush) begin
                    if (miss) buf_load[dsel] = 1'b1;
`ifdef IFP_PREFETCH_EN
                    else if (pf_pending) begin
                        buf_load[~dsel] = 1'b1;
                        ld_tag          = fill_tag + TAG_W'(1);
                    end
`endif
                end
            end
`ifdef IFP_PREFETCH_EN
            ST_PREF: if (ack_ok && !last_word && miss) buf_load[dsel] = 1'b1;
`endif
            default: ;
        endcase
        if (ack_ok) begin
            buf_we[fill_sel] = 1'b1;
            if (last_word && !flush_pending && !flush) buf_set[fill_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < NBUF; i++) begin : g_buf
        ifp_line_buf u_buf (
            .clk        (clk),
            .rst        (rst),
            .clr        (flush),
            .load       (buf_load[i]),
            .load_tag   (ld_tag),
            .we         (buf_we[i]),
            .widx       (word_cnt),
            .wdata      (bus_rdata),
            .set_valid  (buf_set[i]),
            .lookup_tag (tag),
            .lookup_idx (idx),
            .hit        (buf_hit[i]),
            .rdata      (buf_rdata[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus_req       <= 1'b0;
            bus_addr      <= '0;
            fill_tag      <= '0;
            word_cnt      <= '0;
            err_valid     <= 1'b0;
            err_tag       <= '0;
            flush_pending <= 1'b0;
`ifdef IFP_PREFETCH_EN
            pf_pending    <= 1'b0;
            dsel          <= 1'b0;
`endif
        end else begin
            // later assignments (a failing fill) override this clear
            if (flush) err_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    flush_pending <= 1'b0;
                    if (flush) begin
`ifdef IFP_PREFETCH_EN
                        pf_pending <= 1'b0;
`endif
                    end else if (miss) begin
                        fill_tag <= tag;
                        word_cnt <= '0;
                        bus_addr <= line_addr(tag);
                        bus_req  <= 1'b1;
                        state    <= ST_FILL;
                    end
`ifdef IFP_PREFETCH_EN
                    else if (pf_pending) begin
                        pf_pending <= 1'b0;
                        fill_tag   <= fill_tag + TAG_W'(1);
                        word_cnt   <= '0;
                        bus_addr   <= line_addr(fill_tag + TAG_W'(1));
                        bus_req    <= 1'b1;
                        state      <= ST_PREF;
                    end else if (aligned && buf_hit[~dsel]) begin
                        dsel <= ~dsel;
                    end
`endif
                end
                ST_FILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (bus_ack) begin
                        if (bus_err) begin
                            err_valid <= 1'b1;
                            err_tag   <= fill_tag;
                            bus_req   <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (last_word) begin
                            err_valid <= 1'b0;
                            bus_req   <= 1'b0;
                            state     <= ST_IDLE;
`ifdef IFP_PREFETCH_EN
                            pf_pending <= !(flush_pending || flush);
`endif
                        end else begin
                            word_cnt <= word_cnt + IDX_W'(1);
                            bus_addr <= bus_addr + 32'd4;
                        end
                    end
                end
`ifdef IFP_PREFETCH_EN
                ST_PREF: begin
                    if (flush) flush_pending <= 1'b1;
                    if (bus_ack) begin
                        // a prefetch error just leaves the spare line invalid
                        if (bus_err || last_word) begin
                            if (!bus_err) err_valid <= 1'b0;
                            bus_req <= 1'b0;
                            state   <= ST_IDLE;
                        end else if (miss) begin
                            // abort at a word boundary; bus_req stays high
                            fill_tag      <= tag;
                            word_cnt      <= '0;
                            bus_addr      <= line_addr(tag);
                            flush_pending <= 1'b0;
                            state         <= ST_FILL;
                        end else begin
                            word_cnt <= word_cnt + IDX_W'(1);
                            bus_addr <= bus_addr + 32'd4;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_port.sv
// Scoreboard bench for instr_fetch_port: the driver pushes the expected
// response of each fetch, the monitor pops it when fetch_stall drops and
// also checks how many stalled cycles were seen.
`timescale 1ns/1ps
module tb_instr_fetch_port;
    import instr_fetch_port_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [31:0]               fetch_addr;
    logic [31:0]               fetch_data;
    logic [EXC_CODE_WIDTH-1:0] fetch_exc_code;
    logic                      fetch_stall;
    logic                      flush;
    logic                      bus_req;
    logic [31:0]               bus_addr;
    logic                      bus_ack   = 1'b0;
    logic [31:0]               bus_rdata = '0;
    logic                      bus_err   = 1'b0;

    instr_fetch_port dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .fetch_exc_code (fetch_exc_code),
        .fetch_stall    (fetch_stall),
        .flush          (flush),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                      name;
        logic [31:0]                data;
        logic [EXC_CODE_WIDTH-1:0]  exc;
        int                         stall;
    } exp_t;

    exp_t        sb[$];
    int          issued = 0, served = 0, stall_cnt = 0;
    int          checks = 0, errors = 0, ack_cnt = 0;
    logic [31:0] ack_log[$];
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    // memory image: line 0x80000000 holds 0x11..0x44, elsewhere addr^0xDEAD0000
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000000) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return a ^ 32'hDEAD0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    endtask

    // bus slave: answers every request in one cycle
    always @(negedge clk) begin
        bus_ack   = bus_req;
        bus_rdata = bus_req ? mem_word(bus_addr) : 32'h0;
        bus_err   = bus_req && err_en && (bus_addr == err_addr);
    end

    always @(posedge clk) begin
        if (bus_req && bus_ack) begin
            ack_cnt++;
            ack_log.push_back(bus_addr);
        end
    end

    // monitor
    always @(negedge clk) begin
        exp_t e;
        if (served != issued) begin
            if (fetch_stall) stall_cnt++;
            else begin
                if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
                else begin
                    e = sb.pop_front();
                    chk({e.name, "_data"},  fetch_data,            e.data);
                    chk({e.name, "_exc"},   32'(fetch_exc_code),   32'(e.exc));
                    chk({e.name, "_stall"}, 32'(stall_cnt),        32'(e.stall));
                end
                stall_cnt = 0;
                served++;
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [EXC_CODE_WIDTH-1:0] e, input int st);
        exp_t x;
        @(posedge clk); #1;
        x.name = name; x.data = d; x.exc = e; x.stall = st;
        sb.push_back(x);
        fetch_addr = a;
        issued++;
    endtask

    task automatic wait_served();
        int n = 0;
        while (served != issued && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (served != issued) begin
            errors++;
            $display("FAIL serve_timeout: got stall after %0d cycles, expected service", n);
            finish_test();
        end
    endtask

    task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [EXC_CODE_WIDTH-1:0] e, input int st);
        issue(name, a, d, e, st);
        wait_served();
    endtask

    // let any follow-on bus traffic (prefetch) drain
    task automatic settle();
        int idle = 0, n = 0;
        repeat (2) @(negedge clk);
        while (idle < 2 && n < 200) begin
            @(negedge clk);
            idle = bus_req ? 0 : idle + 1;
            n++;
        end
        chk("bus_idle", 32'(idle >= 2), 32'd1);
    endtask

    initial begin
        int   a0, p0, n;
        logic seen;

        rst = 1'b1; flush = 1'b0; fetch_addr = 32'h80000000;
        #3;
        chk("rst_bus_req",  32'(bus_req),        32'd0);
        chk("rst_bus_addr", bus_addr,            32'd0);
        chk("rst_stall",    32'(fetch_stall),    32'd1);
        chk("rst_exc",      32'(fetch_exc_code), 32'(EC_NONE));
        fetch_addr = 32'h80000002;
        #1;
        chk("rst_adel_exc",   32'(fetch_exc_code), 32'(EC_ADEL));
        chk("rst_adel_stall", 32'(fetch_stall),    32'd0);
        #19 rst = 1'b0;

        // demand miss, then hits in the same line
        a0 = ack_cnt;
        fetch("miss_line0", 32'h80000000, 32'h11, EC_NONE, 5);
        chk("miss_line0_acks", 32'(ack_cnt - a0), 32'd4);
        settle();
        fetch("hit_w3", 32'h8000000C, 32'h44, EC_NONE, 0);
        fetch("hit_w1", 32'h80000004, 32'h22, EC_NONE, 0);

        // misaligned: no bus traffic, beats a valid hit
        a0 = ack_cnt;
        fetch("adel_2", 32'h80000002, 32'h0, EC_ADEL, 0);
        fetch("adel_f", 32'h8000000F, 32'h0, EC_ADEL, 0);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (bus_req) seen = 1'b1; end
        chk("adel_no_req",  32'(seen),           32'd0);
        chk("adel_no_acks", 32'(ack_cnt - a0),   32'd0);

        // bus error on word 1 of line 0x80000100
        err_addr = 32'h80000104; err_en = 1'b1;
        a0 = ack_cnt;
        fetch("err_miss", 32'h80000100, 32'h0, EC_IBE, 3);
        chk("err_acks",    32'(ack_cnt - a0), 32'd2);
        chk("err_req_low", 32'(bus_req),      32'd0);
        settle();
        err_en = 1'b0;
        fetch("err_hit_w1", 32'h80000104, 32'h0, EC_IBE, 0);
        fetch("err_hit_w3", 32'h8000010C, 32'h0, EC_IBE, 0);
        // the failed fill overwrote the buffer, so line 0 is refetched
        fetch("refill_line0", 32'h80000000, 32'h11, EC_NONE, 5);
        settle();
        // that successful fill cleared the error entry
        fetch("err_cleared", 32'h80000104, 32'h5EAD0104, EC_NONE, 5);
        settle();

        // flush during word 2: fill completes but line stays invalid, refetched
        a0 = ack_cnt;
        issue("flush_fill", 32'h80000200, 32'h5EAD0200, EC_NONE, 10);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = bus_req && (bus_addr == 32'h80000208);
            n++;
        end
        chk("flush_sync", 32'(seen), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_served();
        chk("flush_fill_acks", 32'(ack_cnt - a0), 32'd8);
        settle();

        // flush while idle
        fetch("hit_pre_flush", 32'h80000208, 32'h5EAD0208, EC_NONE, 0);
        @(posedge clk); #1 fetch_addr = 32'h80000002;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        fetch("flush_idle", 32'h80000208, 32'h5EAD0208, EC_NONE, 5);
        settle();

        // reset mid-fill
        @(posedge clk); #1 fetch_addr = 32'h80000300;
        n = 0;
        while (!bus_req && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_bus_req",  32'(bus_req),     32'd0);
        chk("midrst_bus_addr", bus_addr,         32'd0);
        chk("midrst_stall",    32'(fetch_stall), 32'd1);
        fetch_addr = 32'h80000002;
        @(posedge clk); #2 rst = 1'b0;
        fetch("midrst_miss", 32'h80000300, 32'h5EAD0300, EC_NONE, 5);
        settle();

        // next-line behaviour after a demand fill
        p0 = ack_log.size();
        fetch("line0_again", 32'h80000000, 32'h11, EC_NONE, 5);
        settle();
`ifdef IFP_PREFETCH_EN
        chk("pf_reads", 32'(ack_log.size() - p0), 32'd8);
        for (int i = 0; i < 4; i++)
            if (ack_log.size() > p0 + 4 + i)
                chk($sformatf("pf_addr%0d", i), ack_log[p0 + 4 + i], 32'h80000010 + 32'(4 * i));
        fetch("pf_hit", 32'h80000010, 32'h5EAD0010, EC_NONE, 0);
`else
        chk("no_spec_reads", 32'(ack_log.size() - p0), 32'd4);
        fetch("next_line_miss", 32'h80000010, 32'h5EAD0010, EC_NONE, 5);
`endif

        finish_test();
    end

endmodule
